// File: rtl/prog_loader_pkg.sv
// Shared CPU package: core opcode/state types plus the program-loader FSM
// states and memory geometry constants.
package prog_loader_pkg;

    localparam int MEM_DEPTH = 32;
    localparam int ADDR_W    = 5;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_STA = 4'h2,
        OP_ADD = 4'h3,
        OP_JMP = 4'h4,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        CPU_FETCH,
        CPU_DECODE,
        CPU_EXECUTE
    } state_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CHK,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/prog_loader_counter.sv
// Loadable up-counter with enable, used as the loader's memory address generator.
module prog_loader_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    // NOTE: registers take <= so every flop samples values from before the edge.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a framed byte stream (N, N data bytes, XOR checksum),
// writes the data into CPU memory and releases the CPU only after a clean load.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int MEM_DEPTH = prog_loader_pkg::MEM_DEPTH,
    parameter int ADDR_W    = prog_loader_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              cpu_rst_,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = ADDR_W + 1;

    loader_state_t     state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [7:0]        csum_q, csum_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_data_q, mem_data_d;

    logic              accept;
    logic              hdr_ok;
    logic              last_byte;
    logic              addr_load;
    logic              addr_en;
    logic [ADDR_W-1:0] addr;

    prog_loader_counter #(.W(ADDR_W)) u_addr_cnt (
        .clk        (clk),
        .rst_       (rst_),
        .load_i     (addr_load),
        .load_val_i ('0),
        .en_i       (addr_en),
        .count_o    (addr)
    );

    assign in_ready  = (state_q == HDR) || (state_q == DATA) || (state_q == CHK);
    assign accept    = in_valid && in_ready;
    assign hdr_ok    = (in_data != 8'd0) && (32'(in_data) <= 32'(MEM_DEPTH));
    assign last_byte = ({1'b0, addr} == (n_q - CNT_W'(1)));

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        csum_d     = csum_q;
        mem_wr_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        addr_load  = 1'b0;
        addr_en    = 1'b0;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) state_d = HDR;
            end
            HDR: begin
                if (accept) begin
                    if (hdr_ok) begin
                        state_d   = DATA;
                        n_d       = CNT_W'(in_data);
                        csum_d    = '0;
                        addr_load = 1'b1;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    csum_d     = csum_q ^ in_data;
                    mem_wr_d   = 1'b1;
                    mem_addr_d = addr;
                    mem_data_d = in_data;
                    // The counter stops on the last word so it never wraps past the top.
                    addr_en    = !last_byte;
                    if (last_byte) state_d = CHK;
                end
            end
            CHK: begin
                if (accept) state_d = (in_data == csum_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q    <= IDLE;
            n_q        <= '0;
            csum_q     <= '0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            csum_q     <= csum_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign mem_wr   = mem_wr_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign busy     = in_ready;
    assign done     = (state_q == DONE);
    assign cpu_rst_ = (state_q == DONE);
    assign err      = (state_q == ERR);

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have ports: clk input 1 (single clock, all logic on posedge clk).
REQ-002 SHALL have ports: rst_ input 1; reset is synchronous and active-low.
REQ-003 SHALL have ports: start input 1, pulse requesting a program load.
REQ-004 SHALL have ports: in_valid input 1 and in_data input [7:0], the byte-stream source.
REQ-005 SHALL have ports: in_ready output 1, loader can accept a byte this cycle.
REQ-006 SHALL have ports: mem_wr output 1, mem_addr output [4:0] and mem_data output [7:0], the write port to the 32x8 CPU memory.
REQ-007 SHALL have ports: cpu_rst_ output 1, active-low hold on the CPU.
REQ-008 SHALL have ports: busy output 1, done output 1 and err output 1, all status.
REQ-009 SHALL have parameter MEM_DEPTH, default 32, the number of memory words.
REQ-010 SHALL have parameter ADDR_W, default 5, the memory address width.

Function
REQ-011 A byte SHALL be accepted only on a cycle where in_valid && in_ready are both 1.
REQ-012 The frame SHALL be: header byte N (word count), then N data bytes, then 1 checksum byte equal to the XOR of the N data bytes.
REQ-013 The FSM SHALL have states IDLE, HDR, DATA, CHK, DONE and ERR; in_ready SHALL be 1 only in HDR, DATA and CHK.
REQ-014 IDLE/DONE/ERR SHALL go to HDR on start=1; start SHALL be ignored in HDR, DATA and CHK.
REQ-015 HDR SHALL behave as follows on acceptance: 1<=N<=MEM_DEPTH goes to DATA, latches N, and clears the address counter and checksum; N=0 or N>MEM_DEPTH goes to ERR.
REQ-016 DATA SHALL, per accepted byte, XOR it into the running checksum and write it to the current address, then increment the address. It SHALL go to CHK when the Nth byte is accepted.
REQ-017 Each data-byte write SHALL occur exactly 1 cycle after acceptance: mem_wr=1 for exactly one cycle, with mem_addr and mem_data registered.
REQ-018 Back-to-back accepts SHALL produce back-to-back write cycles with no bubbles.
REQ-019 Data bytes SHALL be written to addresses 0..N-1 in order; the address SHALL never wrap. N=32 SHALL end at address 31 with no write to address 0.
REQ-020 CHK SHALL, on acceptance, compare the byte to the running checksum: a match goes to DONE, a mismatch goes to ERR.
REQ-021 In DONE, done SHALL be 1 and cpu_rst_ SHALL be 1.
REQ-022 In every other state, done SHALL be 0 and cpu_rst_ SHALL be 0, holding the CPU.
REQ-023 In ERR, err SHALL be 1; err SHALL clear only on start or reset.
REQ-024 busy SHALL be 1 in HDR, DATA and CHK, and 0 otherwise.
REQ-025 A restart from DONE SHALL drop cpu_rst_ to 0 in the first cycle of HDR.
REQ-026 When in_valid=0, the loader SHALL wait indefinitely with state, address and checksum held.
REQ-027 mem_wr SHALL never assert outside the write cycles of REQ-017; in particular, none for header or checksum bytes.

Reset
REQ-028 While rst_=0 at posedge clk, the loader SHALL reset to: state IDLE, in_ready=0, mem_wr=0, mem_addr=0, mem_data=0, cpu_rst_=0, busy=0, done=0, err=0, checksum=0, address=0.
REQ-029 A reset mid-load SHALL abort immediately: no further mem_wr, the CPU held, and memory contents left as partially written.

Structure
REQ-030 The loader_state_t enum and the constants MEM_DEPTH and ADDR_W SHALL live in the shared CPU package, alongside opcode_t and state_t.
REQ-031 The address generator SHALL be one instance of the existing counter sub-module: load of 0 on entry to DATA, enable on each data accept.

Verification
REQ-032 Nominal load: start, then N=3, bytes 0x05, 0xA1, 0x3C, then checksum 0x98 -> writes mem[0]=0x05, mem[1]=0xA1, mem[2]=0x3C; then done=1, cpu_rst_=1, err=0.
REQ-033 Bad checksum: same frame with checksum 0x99 -> the 3 writes occur, then ERR: err=1, cpu_rst_=0.
REQ-034 Header bounds: N=0 -> err=1 with no mem_wr; N=33 -> err=1 with no mem_wr; N=32 with 32 bytes -> the last write is to address 31, then done.
REQ-035 Throttling: in_valid toggling 1/0 every cycle during DATA -> writes occur only on accepted bytes, contents correct, no duplicate writes.
REQ-036 Reset mid-load: rst_=0 after 2 of 4 data bytes -> next cycle state is IDLE, mem_wr=0, cpu_rst_=0; a subsequent full frame loads correctly.
REQ-037 Restart and ignored start: start pulsed in DATA is ignored; start in DONE -> cpu_rst_=0 next cycle and a new frame loads.
